alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning ALU settle cycles between driving operands and capturing the result (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid input 1 and cmd_ready output 1: command handshake.
REQ-005 SHALL have ports cmd_a input 8, cmd_b input 8, cmd_op input 4, cmd_sweep input 1 (1 = run opcodes 0..15 on cmd_a/cmd_b; cmd_op ignored).
REQ-006 SHALL have ports alu_a output 8, alu_b output 8, alu_opcode output 4, driving the external ALU.
REQ-007 SHALL have ports alu_out input 16, alu_carry input 1, alu_zero input 1: ALU result and flags.
REQ-008 SHALL have ports res_valid output 1 and res_ready input 1: result handshake.
REQ-009 SHALL have ports res_data output 16, res_carry output 1, res_zero output 1, res_op output 4, res_last output 1 (final result of a command).
REQ-010 SHALL have port busy output 1, high in every state except IDLE.

Function
REQ-011 SHALL implement an FSM with states IDLE, SETTLE and HOLD.
REQ-012 cmd_ready SHALL be 1 only in IDLE; the command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-013 On accept: alu_a/alu_b <= cmd_a/cmd_b; alu_opcode <= cmd_sweep ? 0 : cmd_op; sweep flag latched; settle counter <= 0; IDLE -> SETTLE.
REQ-014 alu_a, alu_b and alu_opcode SHALL be registered and held constant from accept until the FSM returns to IDLE, except for opcode stepping per REQ-018.
REQ-015 In SETTLE the counter SHALL increment each cycle; on the cycle the counter equals SETTLE_CYCLES-1, alu_out, alu_carry, alu_zero and alu_opcode SHALL be captured into res_data, res_carry, res_zero and res_op, and the FSM SHALL go to HOLD.
REQ-016 res_valid SHALL be 1 exactly in HOLD; with SETTLE_CYCLES=1 res_valid rises in the 2nd cycle after the accept edge (latency SETTLE_CYCLES+1).
REQ-017 All res_* outputs SHALL remain stable while res_valid=1 and res_ready=0.
REQ-018 On a HOLD edge with res_ready=1: if sweep and alu_opcode != 15, alu_opcode increments by 1, counter <= 0, HOLD -> SETTLE; otherwise HOLD -> IDLE.
REQ-019 res_last SHALL be 1 in HOLD when sweep=0, or when sweep=1 and res_op=15; otherwise 0.
REQ-020 Opcode stepping SHALL stop at 15 and never wrap to 0 within a sweep.
REQ-021 A new command SHALL NOT be accepted in the same cycle that the last result is consumed; cmd_ready rises the cycle after HOLD -> IDLE.
REQ-022 ALU flags SHALL be passed through unmodified; the block SHALL NOT compute flags.

Reset
REQ-023 On reset (asynchronous, any state), the FSM SHALL go to IDLE, and counter, sweep flag, alu_a, alu_b, alu_opcode, res_data, res_carry, res_zero and res_op SHALL be 0.
REQ-024 During reset, cmd_ready, res_valid, res_last and busy SHALL be 0; cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-025 Reset during SETTLE or HOLD SHALL abort the command with no result delivered.

Structure
REQ-026 Package alu_op_sequencer_pkg SHALL hold the state enum, DATA_W=8, OP_W=4, RES_W=16 and LAST_OP=4'hF.
REQ-027 The block SHALL have no sub-module; the ALU remains external and is connected by the parent.

Verification
REQ-028 Single op: SETTLE_CYCLES=1, cmd_a=8'h69, cmd_b=8'h35, cmd_op=0, stub alu_out=16'h009E -> res_valid 2 cycles after accept, res_data=16'h009E, res_op=0, res_last=1.
REQ-029 Sweep: cmd_a=8'h69, cmd_b=8'h35, cmd_sweep=1, res_ready tied 1 -> 16 results with res_op=0..15 in order, res_last only on op 15, then IDLE.
REQ-030 Backpressure: res_ready=0 for 5 cycles in HOLD -> res_* unchanged, alu_opcode not advanced, cmd_ready=0.
REQ-031 Settle: SETTLE_CYCLES=3, stub changes alu_out from 16'h1111 to 16'h2222 2 cycles after accept -> res_data=16'h2222, res_valid 4 cycles after accept.
REQ-032 Reset mid-sweep at res_op=7 -> all outputs 0 within the reset cycle; after release, cmd_ready=1 and no further results.
REQ-033 Flags: stub alu_zero=1, alu_carry=1 -> res_zero=1, res_carry=1 held through HOLD.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer_pkg
//  Description : Shared widths, state encoding and result record for the
//                ALU operation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_op_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int RES_W  = 16;
    localparam int CNT_W  = 4;

    localparam logic [OP_W-1:0] LAST_OP = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [RES_W-1:0] data;
        logic             carry;
        logic             zero;
        logic [OP_W-1:0]  op;
    } result_t;

endpackage : alu_op_sequencer_pkg
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Drives operands/opcode into an external ALU, waits a fixed
//                settle time and returns the result (single op or 0..15 sweep).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic              cmd_sweep,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [RES_W-1:0]  alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_carry,
    output logic              res_zero,
    output logic [OP_W-1:0]   res_op,
    output logic              res_last,
    output logic              busy
);

    // SETTLE_CYCLES is expected in 1..15 so the terminal count fits CNT_W.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e              r_state_q,  w_state_d;
    logic [CNT_W-1:0]    r_cnt_q,    w_cnt_d;
    logic                r_sweep_q,  w_sweep_d;
    logic [DATA_W-1:0]   r_alu_a_q,  w_alu_a_d;
    logic [DATA_W-1:0]   r_alu_b_q,  w_alu_b_d;
    logic [OP_W-1:0]     r_opcode_q, w_opcode_d;
    result_t             r_res_q,    w_res_d;

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_sweep_d  = r_sweep_q;
        w_alu_a_d  = r_alu_a_q;
        w_alu_b_d  = r_alu_b_q;
        w_opcode_d = r_opcode_q;
        w_res_d    = r_res_q;

        case (r_state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_alu_a_d  = cmd_a;
                    w_alu_b_d  = cmd_b;
                    w_opcode_d = cmd_sweep ? '0 : cmd_op;
                    w_sweep_d  = cmd_sweep;
                    w_cnt_d    = '0;
                    w_state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == C_CNT_LAST) begin
                    w_res_d.data  = alu_out;
                    w_res_d.carry = alu_carry;
                    w_res_d.zero  = alu_zero;
                    w_res_d.op    = r_opcode_q;
                    w_state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    // Sweep steps up to LAST_OP and then stops; it never wraps.
                    if (r_sweep_q && (r_opcode_q != LAST_OP)) begin
                        w_opcode_d = r_opcode_q + 1'b1;
                        w_cnt_d    = '0;
                        w_state_d  = ST_SETTLE;
                    end else begin
                        w_state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= '0;
            r_sweep_q  <= 1'b0;
            r_alu_a_q  <= '0;
            r_alu_b_q  <= '0;
            r_opcode_q <= '0;
            r_res_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_sweep_q  <= w_sweep_d;
            r_alu_a_q  <= w_alu_a_d;
            r_alu_b_q  <= w_alu_b_d;
            r_opcode_q <= w_opcode_d;
            r_res_q    <= w_res_d;
        end
    end

    // cmd_ready is masked by reset so it reads 0 while reset is held.
    assign cmd_ready  = (r_state_q == ST_IDLE) && !reset;
    assign busy       = (r_state_q != ST_IDLE);
    assign res_valid  = (r_state_q == ST_HOLD);
    assign res_last   = res_valid && (!r_sweep_q || (r_res_q.op == LAST_OP));

    assign alu_a      = r_alu_a_q;
    assign alu_b      = r_alu_b_q;
    assign alu_opcode = r_opcode_q;
    assign res_data   = r_res_q.data;
    assign res_carry  = r_res_q.carry;
    assign res_zero   = r_res_q.zero;
    assign res_op     = r_res_q.op;

endmodule : alu_op_sequencer
`default_nettype wire
